uart_baud_frac: RTL and testbench
=================================

UART_BAUD_FRAC -- requirements
Module: uart_baud_frac

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600: baud rate used to derive the reset increment.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: oversample ticks per bit, legal range 4..64.
REQ-004 SHALL have parameter ACC_W, default 24: phase-accumulator width, legal range 12..32.
REQ-005 SHALL have port clk, input, 1 bit: system clock; the block uses this single clock only.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: run the generator when high.
REQ-008 SHALL have port sync_clr, input, 1 bit: one-cycle phase restart, used for start-bit alignment.
REQ-009 SHALL have port inc_wr, input, 1 bit: strobe that loads a new increment.
REQ-010 SHALL have port inc_wdata, input, ACC_W bits: the new phase increment.
REQ-011 SHALL have port os_tick, output, 1 bit: one-cycle pulse at OVERSAMPLE x baud.
REQ-012 SHALL have port mid_tick, output, 1 bit: one-cycle pulse at the mid-bit sample point.
REQ-013 SHALL have port bit_tick, output, 1 bit: one-cycle pulse at each bit boundary.
REQ-014 SHALL have port inc_pend, output, 1 bit: a written increment is waiting to be applied.
REQ-015 SHALL have port inc_err, output, 1 bit: one-cycle pulse when a write is rejected.

Function
REQ-016 SHALL keep an ACC_W-bit accumulator acc; on each enabled cycle, acc <= acc + inc modulo 2^ACC_W, with the carry-out captured.
REQ-017 SHALL register all tick outputs; os_tick is high in the cycle after the edge whose addition carried.
REQ-018 SHALL keep a counter os_cnt running 0..OVERSAMPLE-1 that advances on each carry and wraps to 0 after OVERSAMPLE-1.
REQ-019 SHALL assert bit_tick together with os_tick when the carry takes os_cnt from OVERSAMPLE-1 to 0.
REQ-020 SHALL assert mid_tick together with os_tick when the carry takes os_cnt to OVERSAMPLE/2.
REQ-021 SHALL, when enable is low, hold acc and os_cnt and keep all ticks low.
REQ-022 SHALL treat an inc_wr write as legal when 0 < inc_wdata <= 2^(ACC_W-1).
- Legal write: the value goes into a shadow register and inc_pend is set in the next cycle.
- Illegal write: the value is discarded, inc_err pulses for one cycle, and any existing pending value is kept.
REQ-023 SHALL copy the shadow value into inc and clear inc_pend on the first of three events:
- a bit boundary (the edge that asserts bit_tick);
- any cycle with enable low;
- a sync_clr cycle.
REQ-024 SHALL, when sync_clr is high, set acc and os_cnt to 0 and suppress all ticks for that cycle; sync_clr overrides enable.
REQ-025 SHALL, when inc_wr and an apply event occur in the same cycle, apply the previous shadow value, then load the new one with inc_pend still set; a write of the same value therefore takes effect at the next apply event.
REQ-026 SHALL make consecutive legal writes before an apply event overwrite the shadow (last write wins).
REQ-027 SHALL produce a long-run os_tick rate of exactly CLK_FREQ * inc / 2^ACC_W, with no cumulative drift.

Reset
REQ-028 SHALL, while rst_n is low:
- clear acc, os_cnt, the shadow register, inc_pend and all tick outputs;
- load inc with DEF_INC = round(OVERSAMPLE * BAUDRATE * 2^ACC_W / CLK_FREQ); 51540 for the defaults.
REQ-029 SHALL, when reset is asserted mid-operation, abandon any pending write and any partial bit, with no tick in the cycle reset deasserts.

Structure
REQ-030 SHALL place in a shared package uart_pkg:
- the DEF_INC calculation function;
- the legality limit constant MAX_INC (2^(ACC_W-1));
- the parameter range checks.
REQ-031 SHALL use one sub-module, uart_phase_acc, containing acc, the carry register and the shadow/apply logic; os_cnt and tick decoding stay in the top level.

Verification (bench parameters ACC_W=16, OVERSAMPLE=16)
REQ-032 SHALL cover: reset, then write inc 0x1000 and enable -> os_tick every 16 cycles, bit_tick every 256 cycles, mid_tick 128 cycles after each bit_tick.
REQ-033 SHALL cover: inc 0x6000 from acc=0 -> exactly 3 os_ticks per 8 cycles, repeating pattern, no drift over 10,000 cycles.
REQ-034 SHALL cover: write 0x2000 mid-bit while running at 0x1000 -> inc_pend stays 1 until the next bit_tick; bit spacing then changes 256 -> 128.
REQ-035 SHALL cover: writes of inc_wdata 0 and of 0x8001 -> inc_err pulses once for each, and the rate is unchanged.
REQ-036 SHALL cover: sync_clr at os_cnt=9 -> no tick that cycle; next os_tick 16 cycles later; bit_tick 256 cycles later.
REQ-037 SHALL cover: rst_n pulsed low while inc_pend=1 -> inc_pend 0 and inc = DEF_INC; ticks resume from acc=0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// uart_pkg : shared constants and elaboration-time helpers for the baud block
// Rev 1.0
// =============================================================================
package uart_pkg;

    localparam int unsigned OS_MIN    = 4;
    localparam int unsigned OS_MAX    = 64;
    localparam int unsigned ACC_W_MIN = 12;
    localparam int unsigned ACC_W_MAX = 32;

    // Largest legal increment, 2^(ACC_W-1): beyond this an add could carry on
    // consecutive cycles in a way that aliases the tick rate.
    function automatic longint unsigned max_inc(input int unsigned acc_w);
        return 64'd1 << (acc_w - 1);
    endfunction

    // round(OVERSAMPLE * BAUDRATE * 2^ACC_W / CLK_FREQ)
    function automatic longint unsigned def_inc(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned os,
                                                input int unsigned acc_w);
        longint unsigned num;
        num = 64'(os) * 64'(baud) * (64'd1 << acc_w);
        return (num + 64'(clk_freq / 2)) / 64'(clk_freq);
    endfunction

    function automatic bit params_ok(input int unsigned os, input int unsigned acc_w);
        return (os >= OS_MIN) && (os <= OS_MAX) &&
               (acc_w >= ACC_W_MIN) && (acc_w <= ACC_W_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_phase_acc.sv
`default_nettype none
// =============================================================================
// uart_phase_acc : phase accumulator, carry register and increment shadowing
// Rev 1.0
// =============================================================================
module uart_phase_acc
    import uart_pkg::*;
#(
    parameter int unsigned      ACC_W   = 24,
    parameter logic [ACC_W-1:0] DEF_INC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic             apply_i,
    input  logic             inc_wr_i,
    input  logic [ACC_W-1:0] inc_wdata_i,
    output logic             carry_o,
    output logic             os_tick_o,
    output logic             inc_pend_o,
    output logic             inc_err_o
);
    localparam logic [ACC_W-1:0] MAX_INC = ACC_W'(max_inc(ACC_W));

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [ACC_W:0]   sum;
    logic             wr_legal;

    assign sum      = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry_o  = run_i & sum[ACC_W];
    assign wr_legal = inc_wr_i && (inc_wdata_i != '0) && (inc_wdata_i <= MAX_INC);

    always_comb begin
        acc_d    = acc_q;
        inc_d    = inc_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        tick_d   = carry_o;
        err_d    = inc_wr_i & ~wr_legal;

        if (clr_i) begin
            acc_d = '0;
        end else if (run_i) begin
            acc_d = sum[ACC_W-1:0];
        end

        // Apply first, then accept a same-cycle write so it stays pending.
        if (apply_i && pend_q) begin
            inc_d  = shadow_q;
            pend_d = 1'b0;
        end
        if (wr_legal) begin
            shadow_d = inc_wdata_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            inc_q    <= DEF_INC;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign os_tick_o  = tick_q;
    assign inc_pend_o = pend_q;
    assign inc_err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/uart_baud_frac.sv
`default_nettype none
// =============================================================================
// uart_baud_frac : fractional-N UART oversample / mid-bit / bit tick generator
// Rev 1.0
// =============================================================================
module uart_baud_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUDRATE   = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             inc_wr,
    input  logic [ACC_W-1:0] inc_wdata,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic             inc_pend,
    output logic             inc_err
);
    localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [ACC_W-1:0] DEF_INC  = ACC_W'(def_inc(CLK_FREQ, BAUDRATE, OVERSAMPLE, ACC_W));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

    if (!params_ok(OVERSAMPLE, ACC_W)) begin : g_param_check
        $error("uart_baud_frac: OVERSAMPLE must be 4..64 and ACC_W 12..32");
    end

    logic             run;
    logic             carry;
    logic             bit_wrap;
    logic             mid_hit;
    logic             apply;
    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic             bit_tick_q, bit_tick_d;
    logic             mid_tick_q, mid_tick_d;

    assign run      = enable & ~sync_clr;
    assign bit_wrap = carry & (os_cnt_q == CNT_LAST);
    assign mid_hit  = carry & (os_cnt_q == CNT_MID);
    // A new increment may only land where it cannot split a bit period.
    assign apply    = sync_clr | ~enable | bit_wrap;

    uart_phase_acc #(
        .ACC_W   (ACC_W),
        .DEF_INC (DEF_INC)
    ) u_phase_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run),
        .clr_i       (sync_clr),
        .apply_i     (apply),
        .inc_wr_i    (inc_wr),
        .inc_wdata_i (inc_wdata),
        .carry_o     (carry),
        .os_tick_o   (os_tick),
        .inc_pend_o  (inc_pend),
        .inc_err_o   (inc_err)
    );

    always_comb begin
        os_cnt_d   = os_cnt_q;
        bit_tick_d = bit_wrap;
        mid_tick_d = mid_hit;
        if (sync_clr) begin
            os_cnt_d = '0;
        end else if (carry) begin
            os_cnt_d = bit_wrap ? '0 : os_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q   <= '0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
        end else begin
            os_cnt_q   <= os_cnt_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
        end
    end

    assign bit_tick = bit_tick_q;
    assign mid_tick = mid_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_frac.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_uart_baud_frac : scenario tasks plus randomized run against a phase model
// Rev 1.0
// =============================================================================
module tb_uart_baud_frac;
    localparam int ACC_W    = 16;
    localparam int OS       = 16;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 9600;
    localparam int MOD      = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              sync_clr = 1'b0;
    logic              inc_wr = 1'b0;
    logic [ACC_W-1:0]  inc_wdata = '0;
    logic              os_tick, mid_tick, bit_tick, inc_pend, inc_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int def_inc_m;

    // Reference model: phase as an integer, tick positions from total carry count.
    int m_acc, m_inc, m_shadow, m_carries;
    bit m_pend, e_os, e_mid, e_bit, e_err;

    always #5 clk = ~clk;

    uart_baud_frac #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUDRATE   (BAUD),
        .OVERSAMPLE (OS),
        .ACC_W      (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sync_clr  (sync_clr),
        .inc_wr    (inc_wr),
        .inc_wdata (inc_wdata),
        .os_tick   (os_tick),
        .mid_tick  (mid_tick),
        .bit_tick  (bit_tick),
        .inc_pend  (inc_pend),
        .inc_err   (inc_err)
    );

    task automatic model_reset();
        m_acc = 0; m_inc = def_inc_m; m_shadow = 0; m_pend = 0; m_carries = 0;
        e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit legal, apply_ev;
        int total;
        legal = inc_wr && (int'(inc_wdata) > 0) && (int'(inc_wdata) <= MOD / 2);
        e_err = inc_wr && !legal;
        e_os = 0; e_mid = 0; e_bit = 0; apply_ev = 0;
        if (sync_clr) begin
            m_acc = 0; m_carries = 0; apply_ev = 1;
        end else if (!enable) begin
            apply_ev = 1;
        end else begin
            total = m_acc + m_inc;
            m_acc = total % MOD;
            if (total >= MOD) begin
                m_carries++;
                e_os  = 1;
                e_bit = (m_carries % OS) == 0;
                e_mid = (m_carries % OS) == OS / 2;
                apply_ev = e_bit;
            end
        end
        if (apply_ev && m_pend) begin m_inc = m_shadow; m_pend = 0; end
        if (legal) begin m_shadow = int'(inc_wdata); m_pend = 1; end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        cyc++;
        #1;
    endtask

    task automatic write_inc(input logic [ACC_W-1:0] v);
        inc_wr = 1'b1; inc_wdata = v; step(); inc_wr = 1'b0;
    endtask

    task automatic setup_run(input logic [ACC_W-1:0] v);
        enable = 1'b0; sync_clr = 1'b0;
        write_inc(v);
        step();
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; model_reset();
        step(); step();
        checks++; if (os_tick !== 1'b0)  begin errors++; $display("FAIL reset_os_tick got=%b exp=0", os_tick); end
        checks++; if (mid_tick !== 1'b0) begin errors++; $display("FAIL reset_mid_tick got=%b exp=0", mid_tick); end
        checks++; if (bit_tick !== 1'b0) begin errors++; $display("FAIL reset_bit_tick got=%b exp=0", bit_tick); end
        checks++; if (inc_pend !== 1'b0) begin errors++; $display("FAIL reset_inc_pend got=%b exp=0", inc_pend); end
        checks++; if (inc_err !== 1'b0)  begin errors++; $display("FAIL reset_inc_err got=%b exp=0", inc_err); end
        rst_n = 1'b1; enable = 1'b1;
        step();
        checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL reset_release_tick got=%b exp=0", os_tick); end
        enable = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int t_os, n_os, n_bit, n_mid;
        enable = 1'b0;
        write_inc(16'h1000);
        checks++; if (inc_pend !== 1'b1) begin errors++; $display("FAIL basic_pend_set got=%b exp=1", inc_pend); end
        step();
        checks++; if (inc_pend !== 1'b0) begin errors++; $display("FAIL basic_pend_idle_apply got=%b exp=0", inc_pend); end
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        enable = 1'b1;
        t_os = 0; n_os = 0; n_bit = 0; n_mid = 0;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (os_tick) begin
                checks++;
                if (i - t_os != 16) begin errors++; $display("FAIL basic_os_gap cyc=%0d got=%0d exp=16", cyc, i - t_os); end
                t_os = i; n_os++;
            end
            if (bit_tick) begin
                checks++; n_bit++;
                if (i % 256 != 0 || !os_tick) begin errors++; $display("FAIL basic_bit_pos cyc=%0d got=%0d exp=0 (mod 256)", cyc, i % 256); end
            end
            if (mid_tick) begin
                checks++; n_mid++;
                if (i % 256 != 128 || !os_tick) begin errors++; $display("FAIL basic_mid_pos cyc=%0d got=%0d exp=128 (mod 256)", cyc, i % 256); end
            end
        end
        checks++; if (n_os != 50) begin errors++; $display("FAIL basic_os_count got=%0d exp=50", n_os); end
        checks++; if (n_bit != 3) begin errors++; $display("FAIL basic_bit_count got=%0d exp=3", n_bit); end
        checks++; if (n_mid != 3) begin errors++; $display("FAIL basic_mid_count got=%0d exp=3", n_mid); end
        enable = 1'b0;
    endtask

    task automatic test_frac();
        bit exp_pat[8];
        int cnt, total, bad;
        for (int k = 0; k < 8; k++)
            exp_pat[k] = (((k + 1) * 24576) / MOD) != ((k * 24576) / MOD);
        setup_run(16'h6000);
        total = 0;
        for (int w = 0; w < 1250; w++) begin
            cnt = 0; bad = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (os_tick !== exp_pat[k]) bad++;
                if (os_tick === 1'b1) begin cnt++; total++; end
            end
            checks++;
            if (cnt != 3 || bad != 0) begin errors++; $display("FAIL frac_window w=%0d got=%0d ticks exp=3 (pattern diffs %0d)", w, cnt, bad); end
        end
        checks++;
        if (total != (10000 * 24576) / MOD) begin errors++; $display("FAIL frac_total got=%0d exp=%0d", total, (10000 * 24576) / MOD); end
        enable = 1'b0;
    endtask

    task automatic test_midwrite();
        int bad_pend, nb;
        int bt[3];
        setup_run(16'h1000);
        bad_pend = 0; nb = 0;
        for (int i = 1; i <= 520; i++) begin
            if (i == 101) begin inc_wr = 1'b1; inc_wdata = 16'h2000; end
            step();
            inc_wr = 1'b0;
            if (i >= 101 && i <= 255 && inc_pend !== 1'b1) bad_pend++;
            if (i == 256) begin
                checks++; if (inc_pend !== 1'b0) begin errors++; $display("FAIL midwrite_pend_clear got=%b exp=0", inc_pend); end
            end
            if (bit_tick === 1'b1) begin
                if (nb < 3) bt[nb] = i;
                nb++;
            end
        end
        checks++; if (bad_pend != 0) begin errors++; $display("FAIL midwrite_pend_hold got=%0d low cycles exp=0", bad_pend); end
        checks++; if (nb != 3) begin errors++; $display("FAIL midwrite_bit_count got=%0d exp=3", nb); end
        if (nb >= 3) begin
            checks++; if (bt[0] != 256) begin errors++; $display("FAIL midwrite_bit0 got=%0d exp=256", bt[0]); end
            checks++; if (bt[1] - bt[0] != 128) begin errors++; $display("FAIL midwrite_gap1 got=%0d exp=128", bt[1] - bt[0]); end
            checks++; if (bt[2] - bt[1] != 128) begin errors++; $display("FAIL midwrite_gap2 got=%0d exp=128", bt[2] - bt[1]); end
        end
        enable = 1'b0;
    endtask

    task automatic test_illegal();
        int t_os, n_os;
        setup_run(16'h1000);
        repeat (20) step();
        write_inc(16'h0000);
        checks++; if (inc_err !== 1'b1)  begin errors++; $display("FAIL illegal_zero_err got=%b exp=1", inc_err); end
        checks++; if (inc_pend !== 1'b0) begin errors++; $display("FAIL illegal_zero_pend got=%b exp=0", inc_pend); end
        step();
        checks++; if (inc_err !== 1'b0)  begin errors++; $display("FAIL illegal_zero_once got=%b exp=0", inc_err); end
        write_inc(16'h8001);
        checks++; if (inc_err !== 1'b1)  begin errors++; $display("FAIL illegal_big_err got=%b exp=1", inc_err); end
        step();
        checks++; if (inc_err !== 1'b0)  begin errors++; $display("FAIL illegal_big_once got=%b exp=0", inc_err); end
        t_os = -1; n_os = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (os_tick === 1'b1) begin
                if (t_os >= 0) begin
                    checks++;
                    if (i - t_os != 16) begin errors++; $display("FAIL illegal_rate_gap cyc=%0d got=%0d exp=16", cyc, i - t_os); end
                end
                t_os = i; n_os++;
            end
        end
        checks++; if (n_os < 18) begin errors++; $display("FAIL illegal_rate_count got=%0d exp>=18", n_os); end
        inc_wr = 1'b1; inc_wdata = 16'h3000; step();
        inc_wdata = 16'h0000; step(); inc_wr = 1'b0;
        checks++; if ({inc_err, inc_pend} !== 2'b11) begin errors++; $display("FAIL illegal_keeps_pend got=%b exp=11", {inc_err, inc_pend}); end
        write_inc(16'h8000);
        checks++; if ({inc_err, inc_pend} !== 2'b01) begin errors++; $display("FAIL max_legal got=%b exp=01", {inc_err, inc_pend}); end
        enable = 1'b0; step();
        checks++; if (inc_pend !== 1'b0) begin errors++; $display("FAIL illegal_disable_apply got=%b exp=0", inc_pend); end
    endtask

    task automatic test_sync();
        int n_os, first_os, first_bit;
        setup_run(16'h1000);
        n_os = 0;
        for (int i = 1; i <= 159; i++) begin
            step();
            if (os_tick === 1'b1) n_os++;
        end
        checks++; if (n_os != 9) begin errors++; $display("FAIL sync_pre_count got=%0d exp=9", n_os); end
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        checks++; if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin errors++; $display("FAIL sync_suppress got=%b exp=000", {os_tick, mid_tick, bit_tick}); end
        first_os = -1; first_bit = -1;
        for (int j = 1; j <= 300; j++) begin
            step();
            if (os_tick === 1'b1 && first_os < 0) first_os = j;
            if (bit_tick === 1'b1 && first_bit < 0) first_bit = j;
        end
        checks++; if (first_os != 16)  begin errors++; $display("FAIL sync_next_os got=%0d exp=16", first_os); end
        checks++; if (first_bit != 256) begin errors++; $display("FAIL sync_next_bit got=%0d exp=256", first_bit); end
        enable = 1'b0;
    endtask

    task automatic test_reset_pending();
        int first_os, bad_pend, exp_first;
        setup_run(16'h1000);
        repeat (50) step();
        write_inc(16'h2000);
        checks++; if (inc_pend !== 1'b1) begin errors++; $display("FAIL rstpend_set got=%b exp=1", inc_pend); end
        #2 rst_n = 1'b0; model_reset();
        #1;
        checks++; if ({os_tick, mid_tick, bit_tick, inc_pend, inc_err} !== 5'b0) begin errors++; $display("FAIL rstpend_async_clear got=%b exp=00000", {os_tick, mid_tick, bit_tick, inc_pend, inc_err}); end
        step();
        rst_n = 1'b1;
        exp_first = (MOD + def_inc_m - 1) / def_inc_m;
        first_os = -1; bad_pend = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (i == 1) begin
                checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL rstpend_release_tick got=%b exp=0", os_tick); end
            end
            if (os_tick === 1'b1 && first_os < 0) first_os = i;
            if (inc_pend !== 1'b0) bad_pend++;
        end
        checks++; if (first_os != exp_first) begin errors++; $display("FAIL rstpend_def_rate got=%0d exp=%0d", first_os, exp_first); end
        checks++; if (bad_pend != 0) begin errors++; $display("FAIL rstpend_pend_abandoned got=%0d exp=0", bad_pend); end
        enable = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] got, exp;
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 15) != 0);
            sync_clr = ($urandom_range(0, 63) == 0);
            inc_wr   = ($urandom_range(0, 23) == 0);
            case ($urandom_range(0, 5))
                0:       inc_wdata = 16'h0000;
                1:       inc_wdata = 16'h8000;
                2:       inc_wdata = 16'h8001;
                3:       inc_wdata = 16'hFFFF;
                default: inc_wdata = 16'($urandom_range(16'h0400, 16'h8000));
            endcase
            step();
            got = {os_tick, mid_tick, bit_tick, inc_pend, inc_err};
            exp = {e_os, e_mid, e_bit, m_pend, e_err};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random_outputs cyc=%0d got=%b exp=%b (os mid bit pend err)", cyc, got, exp); end
        end
        enable = 1'b0; sync_clr = 1'b0; inc_wr = 1'b0;
    endtask

    initial begin
        def_inc_m = int'(real'(OS) * real'(BAUD) * real'(MOD) / real'(CLK_FREQ));
        test_reset();
        test_basic();
        test_frac();
        test_midwrite();
        test_illegal();
        test_sync();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
